// File: rtl/fetch_queue.sv
// Sequential-PC fetch unit with a DEPTH-entry instruction queue, credit-limited requests and redirect flush.
// Optional statistics counters are enabled with `define FETCH_QUEUE_STATS_EN.
module fetch_queue #(
    parameter int unsigned          DWIDTH   = 32,
    parameter int unsigned          AWIDTH   = 32,
    parameter logic [AWIDTH-1:0]    BASEADDR = AWIDTH'(32'h0100_0000),
    parameter int unsigned          DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                redirect_valid_i,
    input  logic [AWIDTH-1:0]   redirect_pc_i,
    output logic                imem_req_valid_o,
    input  logic                imem_req_ready_i,
    output logic [AWIDTH-1:0]   imem_req_addr_o,
    input  logic                imem_rsp_valid_i,
    input  logic [DWIDTH-1:0]   imem_rsp_data_i,
    output logic                insn_valid_o,
    input  logic                insn_ready_i,
    output logic [AWIDTH-1:0]   pc_o,
    output logic [DWIDTH-1:0]   insn_o
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]         stat_fetched_o,
    output logic [31:0]         stat_dropped_o,
    output logic [15:0]         stat_redirects_o
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t             state;
    logic [AWIDTH-1:0]  fetch_pc;
    logic [AWIDTH-1:0]  rsp_pc;
    logic [AWIDTH-1:0]  q_pc   [DEPTH];
    logic [DWIDTH-1:0]  q_insn [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [CW-1:0]      outstanding;
    logic [CW-1:0]      stale;

    logic [CW:0]        credit_used;
    logic [CW-1:0]      left_in_flight;
    logic [AWIDTH-1:0]  redirect_pc;
    logic               req_fire;
    logic               push;
    logic               pop;
    logic               unused_pc_lsbs;

    assign unused_pc_lsbs = ^redirect_pc_i[1:0];
    assign redirect_pc    = {redirect_pc_i[AWIDTH-1:2], 2'b00};

    // Requests in flight plus entries already queued may never exceed the queue size.
    assign credit_used    = {1'b0, outstanding} + {1'b0, count};
    assign left_in_flight = outstanding - CW'(imem_rsp_valid_i);

    assign imem_req_valid_o = rst && (state == RUN) && !redirect_valid_i
                              && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr_o  = fetch_pc;
    assign insn_valid_o     = rst && (count != '0) && !redirect_valid_i;
    assign pc_o             = q_pc[rd_ptr];
    assign insn_o           = q_insn[rd_ptr];

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign push     = imem_rsp_valid_i && (state == RUN) && !redirect_valid_i;
    assign pop      = insn_valid_o && insn_ready_i;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= RUN;
            fetch_pc    <= BASEADDR;
            rsp_pc      <= BASEADDR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]   <= '0;
                q_insn[i] <= '0;
            end
        end else if (redirect_valid_i) begin
            // A response landing in the redirect cycle belongs to the old stream and is dropped.
            fetch_pc    <= redirect_pc;
            rsp_pc      <= redirect_pc;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            outstanding <= left_in_flight;
            stale       <= left_in_flight;
            state       <= (left_in_flight != '0) ? FLUSH : RUN;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + AWIDTH'(4);
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid_i);
            if (state == FLUSH) begin
                if (imem_rsp_valid_i) begin
                    stale <= stale - CW'(1);
                    if (stale == CW'(1)) begin
                        state <= RUN;
                    end
                end
            end else if (push) begin
                q_pc[wr_ptr]   <= rsp_pc;
                q_insn[wr_ptr] <= imem_rsp_data_i;
                wr_ptr         <= wr_ptr + PW'(1);
                rsp_pc         <= rsp_pc + AWIDTH'(4);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_fetched_o   <= '0;
            stat_dropped_o   <= '0;
            stat_redirects_o <= '0;
        end else begin
            if (req_fire) begin
                stat_fetched_o <= stat_fetched_o + 32'd1;
            end
            if (imem_rsp_valid_i && (redirect_valid_i || state == FLUSH)) begin
                stat_dropped_o <= stat_dropped_o + 32'd1;
            end
            if (redirect_valid_i) begin
                stat_redirects_o <= stat_redirects_o + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: in-order memory model, PC-stream reference model, directed and random phases.
// Builds with or without FETCH_QUEUE_STATS_EN.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0100_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i = 1'b0;
    logic [31:0] imem_rsp_data_i = '0;
    logic        insn_valid_o;
    logic        insn_ready_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
`ifdef FETCH_QUEUE_STATS_EN
    logic [31:0] stat_fetched_o;
    logic [31:0] stat_dropped_o;
    logic [15:0] stat_redirects_o;
`endif

    fetch_queue #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .insn_valid_o     (insn_valid_o),
        .insn_ready_i     (insn_ready_i),
        .pc_o             (pc_o),
        .insn_o           (insn_o)
`ifdef FETCH_QUEUE_STATS_EN
        ,
        .stat_fetched_o   (stat_fetched_o),
        .stat_dropped_o   (stat_dropped_o),
        .stat_redirects_o (stat_redirects_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } pend_t;

    int          checks = 0;
    int          errors = 0;
    bit          armed = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_due = 0;
    int          cur_gen = 0;
    int          rsp_gen = 0;
    int          arrived = 0;
    logic [31:0] model_pc = BASE;
    pend_t       pend[$];
    logic [31:0] sb[$];
    logic [31:0] m_fetched = '0;
    logic [31:0] m_dropped = '0;
    logic [15:0] m_redirects = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Stimulus: drive one cycle of inputs just after the edge; memory answers in order.
    task automatic drive(input logic rdy, input logic drdy, input logic redir,
                         input logic [31:0] tgt, input logic rstv);
        @(posedge clk);
        #1;
        cyc++;
        rst              = rstv;
        imem_req_ready_i = rdy;
        insn_ready_i     = drdy;
        redirect_valid_i = redir;
        redirect_pc_i    = tgt;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = mem_word(pend[0].addr);
            rsp_gen          = pend[0].gen;
            void'(pend.pop_front());
        end else begin
            imem_rsp_valid_i = 1'b0;
            imem_rsp_data_i  = $urandom;
        end
    endtask

    // Monitor/scoreboard: reference model predicts handshakes for the coming edge.
    task automatic mon_step();
        bit          any_stale;
        bit          exp_req;
        bit          exp_iv;
        logic [31:0] exp_pc;
        int          due;
        if (!rst) begin
            chk("req_valid_in_reset", imem_req_valid_o, 1'b0);
            pend.delete();
            sb.delete();
            arrived     = 0;
            cur_gen++;
            model_pc    = BASE;
            last_due    = 0;
            m_fetched   = '0;
            m_dropped   = '0;
            m_redirects = '0;
            return;
        end
        any_stale = imem_rsp_valid_i && (rsp_gen != cur_gen);
        foreach (pend[i]) if (pend[i].gen != cur_gen) any_stale = 1'b1;
        exp_req = !redirect_valid_i && !any_stale && (sb.size() < DEPTH);
        exp_iv  = !redirect_valid_i && (arrived > 0);
        chk("req_valid", imem_req_valid_o, exp_req);
        chk("insn_valid", insn_valid_o, exp_iv);
`ifdef FETCH_QUEUE_STATS_EN
        chk("stat_fetched", stat_fetched_o, m_fetched);
        chk("stat_dropped", stat_dropped_o, m_dropped);
        chk("stat_redirects", stat_redirects_o, m_redirects);
`endif
        if (redirect_valid_i) begin
            m_redirects++;
            if (imem_rsp_valid_i) m_dropped++;
            sb.delete();
            arrived  = 0;
            cur_gen++;
            model_pc = {redirect_pc_i[31:2], 2'b00};
            return;
        end
        if (imem_req_valid_o && imem_req_ready_i) begin
            chk("req_addr", imem_req_addr_o, model_pc);
            sb.push_back(model_pc);
            due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            pend.push_back('{imem_req_addr_o, cur_gen, due});
            last_due = due;
            model_pc = model_pc + 32'd4;
            m_fetched++;
        end
        if (imem_rsp_valid_i) begin
            if (rsp_gen == cur_gen) arrived++;
            else m_dropped++;
        end
        if (insn_valid_o && insn_ready_i) begin
            if (sb.size() == 0) begin
                chk("pop_with_empty_model", 1'b1, 1'b0);
            end else begin
                exp_pc = sb.pop_front();
                chk("pop_pc", pc_o, exp_pc);
                chk("pop_insn", insn_o, mem_word(exp_pc));
                arrived--;
            end
        end
    endtask

    always @(negedge clk) if (armed) mon_step();

    task automatic do_reset();
        repeat (2) drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        int  acc;
        bit  found;
        bit  rdy, drdy, redir, rstv;
        logic [31:0] tgt;

        // Reset values and first-fetch latency with a 1-cycle memory.
        lat = 1;
        repeat (3) drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        armed = 1;
        @(negedge clk);
        chk("rst_req_valid", imem_req_valid_o, 1'b0);
        chk("rst_req_addr", imem_req_addr_o, BASE);
        chk("rst_insn_valid", insn_valid_o, 1'b0);
        chk("rst_pc", pc_o, 32'h0);
        chk("rst_insn", insn_o, 32'h0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("first_req_valid", imem_req_valid_o, 1'b1);
        chk("first_req_addr", imem_req_addr_o, BASE);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("second_req_addr", imem_req_addr_o, BASE + 32'd4);
        chk("insn_valid_early", insn_valid_o, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("third_req_addr", imem_req_addr_o, BASE + 32'd8);
        chk("first_insn_valid", insn_valid_o, 1'b1);
        chk("first_pc", pc_o, BASE);
        chk("first_insn", insn_o, mem_word(BASE));

        // Decode stalled: credit caps accepts at DEPTH, then resume at BASE+16.
        do_reset();
        acc = 0;
        repeat (12) begin
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (imem_req_valid_o && imem_req_ready_i) acc++;
        end
        chk("full_accepts", acc, DEPTH);
        chk("full_req_valid", imem_req_valid_o, 1'b0);
        chk("full_head_pc", pc_o, BASE);
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (imem_req_valid_o) begin
                found = 1;
                chk("resume_addr", imem_req_addr_o, BASE + 32'h10);
            end
        end
        chk("resume_seen", found, 1'b1);

        // Three in flight on a 4-cycle memory, redirect to an unaligned target.
        lat = 4;
        do_reset();
        repeat (3) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            chk("flush_setup_accept", imem_req_valid_o, 1'b1);
        end
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0102, 1'b1);
        @(negedge clk);
        chk("redir_req_gated", imem_req_valid_o, 1'b0);
        found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (imem_req_valid_o) begin
                found = 1;
                chk("flush_len", i, 4);
                chk("redir_first_addr", imem_req_addr_o, 32'h0000_0100);
            end
        end
        chk("redir_req_seen", found, 1'b1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (insn_valid_o) begin
                found = 1;
                chk("redir_first_pc", pc_o, 32'h0000_0100);
            end
        end
        chk("redir_insn_seen", found, 1'b1);

        // Redirect coinciding with a response and a decode handshake.
        lat = 2;
        do_reset();
        repeat (6) drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b1);
        @(negedge clk);
        chk("coincide_rsp_present", imem_rsp_valid_i, 1'b1);
        chk("coincide_insn_valid", insn_valid_o, 1'b0);
        chk("coincide_req_valid", imem_req_valid_o, 1'b0);
        found = 0;
        for (int i = 1; i <= 20 && !found; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (imem_req_valid_o) begin
                found = 1;
                chk("coincide_flush_len", i, 2);
                chk("coincide_addr", imem_req_addr_o, 32'h0000_2000);
            end
        end
        chk("coincide_req_seen", found, 1'b1);

        // Address wrap at the top of the PC space.
        lat = 1;
        drive(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        acc = 0;
        for (int i = 0; i < 30 && acc < 2; i++) begin
            drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
            @(negedge clk);
            if (imem_req_valid_o) begin
                chk("wrap_addr", imem_req_addr_o, (acc == 0) ? 32'hFFFF_FFFC : 32'h0000_0000);
                acc++;
            end
        end
        chk("wrap_seen", acc, 2);

        // Reset with a full queue.
        repeat (10) drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("prereset_full", insn_valid_o, 1'b1);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        chk("postreset_insn_valid", insn_valid_o, 1'b0);
        chk("postreset_addr", imem_req_addr_o, BASE);
`ifdef FETCH_QUEUE_STATS_EN
        chk("postreset_stat_fetched", stat_fetched_o, 32'h0);
        chk("postreset_stat_dropped", stat_dropped_o, 32'h0);
        chk("postreset_stat_redirects", stat_redirects_o, 32'h0);
`endif

        // Random traffic against the scoreboard.
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) lat = $urandom_range(1, 4);
            rdy   = ($urandom_range(0, 3) != 0);
            drdy  = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 39) == 0);
            tgt   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15))) : $urandom;
            rstv  = ($urandom_range(0, 699) != 0);
            drive(rdy, drdy, redir, tgt, rstv);
        end
        repeat (30) drive(1'b1, 1'b1, 1'b0, '0, 1'b1);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
